// File: rtl/game_pkg.sv
// Shared encodings for the game controller: state codes, direction codes,
// default layer count and the control-priority helper.
package game_pkg;

    localparam int NUM_LAYERS_DEF = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_INIT       = 3'd0;
    localparam state_t ST_IDLE       = 3'd1;
    localparam state_t ST_ATTACK     = 3'd2;
    localparam state_t ST_MOVE       = 3'd3;
    localparam state_t ST_DRAW_START = 3'd4;
    localparam state_t ST_DRAW_WAIT  = 3'd5;
    localparam state_t ST_FRAME_DONE = 3'd6;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Opposing presses resolve up over down and left over right.
    function automatic logic [1:0] pick_dir(input logic up, input logic down,
                                            input logic left, input logic right);
        logic [1:0] d;
        d = DIR_RIGHT;
        if (up)
            d = DIR_UP;
        else if (down)
            d = DIR_DOWN;
        else if (left)
            d = DIR_LEFT;
        else if (right)
            d = DIR_RIGHT;
        return d;
    endfunction

endpackage

// File: rtl/game_timer.sv
// Loadable down-counter with zero flag; stops at zero until reloaded.
module game_timer #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/game_fsm.sv
// Game frame controller: input sampling on frame_tick, move/attack, layered draw.
// Optional per-layer draw watchdog enabled by GAME_FSM_DRAW_TIMEOUT_EN.
module game_fsm
    import game_pkg::*;
#(
    parameter int NUM_LAYERS    = NUM_LAYERS_DEF,
    parameter int ATTACK_CYCLES = 16,
    parameter int DRAW_TIMEOUT  = 65536,
    parameter int LW            = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          frame_tick,
    input  logic          c_up,
    input  logic          c_down,
    input  logic          c_left,
    input  logic          c_right,
    input  logic          c_attack,
    input  logic          draw_done,
    output logic          init,
    output logic          idle,
    output logic          attack,
    output logic          move,
    output logic [1:0]    dir,
    output logic [1:0]    facing,
    output logic          draw_start,
    output logic          draw_busy,
    output logic          frame_done,
    output logic          frame_overrun,
    output logic [LW-1:0] layer,
    output logic          draw_timeout_err
);

    // state       | meaning
    // INIT        | one cycle after reset
    // IDLE        | waiting for frame_tick
    // ATTACK      | attack held for ATTACK_CYCLES cycles
    // MOVE        | one-cycle move strobe, facing updated at end
    // DRAW_START  | draw_start pulse for current layer
    // DRAW_WAIT   | waiting for draw_done (or watchdog)
    // FRAME_DONE  | frame_done pulse, layer back to 0

    localparam int TMAX = (ATTACK_CYCLES > DRAW_TIMEOUT) ? ATTACK_CYCLES : DRAW_TIMEOUT;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

    state_t         state;
    logic           t_load;
    logic [TW-1:0]  t_val;
    logic           t_zero;
    logic           draw_adv;
    logic           any_dir;

    assign any_dir = c_up | c_down | c_left | c_right;

    // One timer serves both attack length and the draw watchdog; they never overlap.
    always_comb begin
        t_load = 1'b0;
        t_val  = TW'(ATTACK_CYCLES - 1);
        if (state == ST_IDLE && frame_tick && c_attack)
            t_load = 1'b1;
`ifdef GAME_FSM_DRAW_TIMEOUT_EN
        if (state == ST_DRAW_START) begin
            t_load = 1'b1;
            t_val  = TW'(DRAW_TIMEOUT - 1);
        end
`endif
    end

    game_timer #(.W(TW)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

`ifdef GAME_FSM_DRAW_TIMEOUT_EN
    logic wd_fire;
    logic err_q;

    assign wd_fire  = (state == ST_DRAW_WAIT) && !draw_done && t_zero;
    assign draw_adv = draw_done | wd_fire;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else if (wd_fire)
            err_q <= 1'b1;
    end

    assign draw_timeout_err = err_q;
`else
    assign draw_adv         = draw_done;
    assign draw_timeout_err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_INIT;
            layer         <= '0;
            dir           <= DIR_UP;
            facing        <= DIR_DOWN;
            frame_overrun <= 1'b0;
        end else begin
            // Ticks arriving outside IDLE are dropped, only flagged.
            frame_overrun <= frame_tick && (state != ST_IDLE);
            case (state)
                ST_INIT: begin
                    layer <= '0;
                    state <= ST_DRAW_START;
                end
                ST_IDLE: begin
                    if (frame_tick) begin
                        if (c_attack) begin
                            state <= ST_ATTACK;
                        end else if (any_dir) begin
                            dir   <= pick_dir(c_up, c_down, c_left, c_right);
                            state <= ST_MOVE;
                        end else begin
                            state <= ST_DRAW_START;
                        end
                    end
                end
                ST_MOVE: begin
                    facing <= dir;
                    state  <= ST_DRAW_START;
                end
                ST_ATTACK: begin
                    if (t_zero)
                        state <= ST_DRAW_START;
                end
                ST_DRAW_START: begin
                    state <= ST_DRAW_WAIT;
                end
                ST_DRAW_WAIT: begin
                    if (draw_adv) begin
                        if (layer < LAST_LAYER) begin
                            layer <= layer + 1'b1;
                            state <= ST_DRAW_START;
                        end else begin
                            state <= ST_FRAME_DONE;
                        end
                    end
                end
                ST_FRAME_DONE: begin
                    layer <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    layer <= '0;
                    state <= ST_INIT;
                end
            endcase
        end
    end

    assign init       = (state == ST_INIT);
    assign idle       = (state == ST_IDLE);
    assign attack     = (state == ST_ATTACK);
    assign move       = (state == ST_MOVE);
    assign draw_start = (state == ST_DRAW_START);
    assign draw_busy  = (state == ST_DRAW_START) || (state == ST_DRAW_WAIT);
    assign frame_done = (state == ST_FRAME_DONE);

endmodule

// File: tb/tb_game_fsm.sv
// Self-checking bench for game_fsm: vector table from IDLE plus directed
// sequences for attack length, overrun, watchdog and mid-attack reset.
module tb_game_fsm;

    localparam int NL = 3;
    localparam int AC = 16;
    localparam int DT = 8;
    localparam int LW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          frame_tick = 1'b0;
    logic          c_up = 1'b0, c_down = 1'b0, c_left = 1'b0, c_right = 1'b0, c_attack = 1'b0;
    logic          draw_done = 1'b0;
    logic          init, idle, attack, move;
    logic [1:0]    dir, facing;
    logic          draw_start, draw_busy, frame_done, frame_overrun;
    logic [LW-1:0] layer;
    logic          draw_timeout_err;

    int total = 0;
    int bad   = 0;

    game_fsm #(.NUM_LAYERS(NL), .ATTACK_CYCLES(AC), .DRAW_TIMEOUT(DT)) dut (
        .clock            (clock),
        .reset            (reset),
        .frame_tick       (frame_tick),
        .c_up             (c_up),
        .c_down           (c_down),
        .c_left           (c_left),
        .c_right          (c_right),
        .c_attack         (c_attack),
        .draw_done        (draw_done),
        .init             (init),
        .idle             (idle),
        .attack           (attack),
        .move             (move),
        .dir              (dir),
        .facing           (facing),
        .draw_start       (draw_start),
        .draw_busy        (draw_busy),
        .frame_done       (frame_done),
        .frame_overrun    (frame_overrun),
        .layer            (layer),
        .draw_timeout_err (draw_timeout_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [4:0] ctrl;       // {attack, up, down, left, right}
        logic       exp_move;
        logic [1:0] exp_dir;
        logic       exp_attack;
        logic       exp_ds;
        logic [1:0] exp_facing;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Runs the draw handshake (done 3 cycles after each draw_start) until IDLE.
    task automatic wait_idle(input int first_layer, input int exp_frames);
        int d = -1;
        int nxt = first_layer;
        int frames = 0;
        int n = 0;
        while (!idle && n < 300) begin
            if (draw_start) begin
                chk("layer_order", int'(layer), nxt);
                nxt++;
                d = 3;
                draw_done = 1'b0;
            end else if (d > 0) begin
                d--;
                draw_done = (d == 0);
            end else begin
                draw_done = 1'b0;
            end
            if (frame_done) frames++;
            step();
            n++;
        end
        draw_done = 1'b0;
        chk("reach_idle", int'(idle), 1);
        chk("layers_drawn", nxt, NL);
        chk("frame_count", frames, exp_frames);
    endtask

    task automatic set_ctrl(input logic [4:0] c);
        {c_attack, c_up, c_down, c_left, c_right} = c;
    endtask

    initial begin
        int n;
        int moved;
        int stay;

        vecs[0] = '{5'b01100, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0};
        vecs[1] = '{5'b00011, 1'b1, 2'd2, 1'b0, 1'b0, 2'd2};
        vecs[2] = '{5'b00100, 1'b1, 2'd1, 1'b0, 1'b0, 2'd1};
        vecs[3] = '{5'b00000, 1'b0, 2'd1, 1'b0, 1'b1, 2'd1};
        vecs[4] = '{5'b11000, 1'b0, 2'd1, 1'b1, 1'b0, 2'd1};
        vecs[5] = '{5'b00010, 1'b1, 2'd2, 1'b0, 1'b0, 2'd2};
        vecs[6] = '{5'b00001, 1'b1, 2'd3, 1'b0, 1'b0, 2'd3};

        // Reset values while reset is held
        #12;
        chk("rst_init", int'(init), 1);
        chk("rst_layer", int'(layer), 0);
        chk("rst_facing", int'(facing), 1);
        chk("rst_dir", int'(dir), 0);
        chk("rst_strobes", int'({move, draw_start, frame_done, frame_overrun, attack}), 0);
        chk("rst_err", int'(draw_timeout_err), 0);
        reset = 1'b0;
        #1;
        chk("init_after_rel", int'(init), 1);
        step();
        chk("first_draw_start", int'(draw_start), 1);
        wait_idle(0, 1);

        // Vector table: one frame per entry, starting from IDLE
        for (int i = 0; i < 7; i++) begin
            set_ctrl(vecs[i].ctrl);
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            set_ctrl(5'b00000);
            chk($sformatf("v%0d_move", i), int'(move), int'(vecs[i].exp_move));
            chk($sformatf("v%0d_dir", i), int'(dir), int'(vecs[i].exp_dir));
            chk($sformatf("v%0d_attack", i), int'(attack), int'(vecs[i].exp_attack));
            chk($sformatf("v%0d_draw_start", i), int'(draw_start), int'(vecs[i].exp_ds));
            chk($sformatf("v%0d_no_overrun", i), int'(frame_overrun), 0);
            wait_idle(0, 1);
            chk($sformatf("v%0d_facing", i), int'(facing), int'(vecs[i].exp_facing));
        end

        // Attack duration with a direction held alongside
        set_ctrl(5'b10001);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        n = 0;
        moved = 0;
        while (attack && n < 40) begin
            if (move) moved++;
            n++;
            step();
        end
        set_ctrl(5'b00000);
        chk("attack_len", n, AC);
        chk("attack_no_move", moved, 0);
        chk("attack_then_draw", int'(draw_start), 1);
        wait_idle(0, 1);
        chk("attack_facing_kept", int'(facing), 3);

        // Tick during DRAW_WAIT: overrun pulse, no extra frame
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        chk("ovr_in_wait", int'(draw_busy && !draw_start), 1);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("ovr_pulse", int'(frame_overrun), 1);
        chk("ovr_still_busy", int'(draw_busy), 1);
        step();
        chk("ovr_one_cycle", int'(frame_overrun), 0);
        draw_done = 1'b1;
        step();
        draw_done = 1'b0;
        wait_idle(1, 1);
        stay = 0;
        for (int i = 0; i < 10; i++) begin
            if (idle && !draw_start) stay++;
            step();
        end
        chk("ovr_not_queued", stay, 10);

        // Draw watchdog (or its absence in the default build)
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("wd_draw_start", int'(draw_start), 1);
`ifdef GAME_FSM_DRAW_TIMEOUT_EN
        for (int i = 0; i < DT; i++) step();
        chk("wd_err_before", int'(draw_timeout_err), 0);
        chk("wd_wait_layer0", int'(layer), 0);
        step();
        chk("wd_err_set", int'(draw_timeout_err), 1);
        chk("wd_layer_adv", int'(layer), 1);
        chk("wd_restart", int'(draw_start), 1);
        wait_idle(1, 1);
        chk("wd_err_sticky", int'(draw_timeout_err), 1);
`else
        for (int i = 0; i < 30; i++) step();
        chk("nowd_err", int'(draw_timeout_err), 0);
        chk("nowd_busy", int'(draw_busy), 1);
        chk("nowd_layer", int'(layer), 0);
        draw_done = 1'b1;
        step();
        draw_done = 1'b0;
        wait_idle(1, 1);
`endif

        // Asynchronous reset in the middle of an attack
        set_ctrl(5'b10000);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        set_ctrl(5'b00000);
        step();
        step();
        chk("mid_attack", int'(attack), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_attack", int'(attack), 0);
        chk("arst_init", int'(init), 1);
        chk("arst_facing", int'(facing), 1);
        chk("arst_dir", int'(dir), 0);
        chk("arst_busy", int'(draw_busy), 0);
        chk("arst_strobes", int'({move, draw_start, frame_done, frame_overrun}), 0);
        chk("arst_err", int'(draw_timeout_err), 0);
        #10;
        reset = 1'b0;
        #1;
        chk("arst_restart_init", int'(init), 1);
        step();
        chk("arst_draw_start", int'(draw_start), 1);
        wait_idle(0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
